// File: rtl/ccff_chain_loader.sv
// Configuration-chain initiator: serialises bitstream words onto a CCFF chain, LSB first.
// Optional CRC-16-CCITT of the shifted bits is enabled with `define CCFF_CRC_EN.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 8,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              ccff_clk_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic [15:0]       tail_ones
`ifdef CCFF_CRC_EN
    ,
    output logic [15:0]       crc
`endif
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int SUB_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [SUB_W-1:0] LAST_SUB = SUB_W'(WORD_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SHIFT,
        FIN
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [WORD_W-1:0] shift_reg;
    logic [SUB_W-1:0]  sub_cnt;
    logic [CNT_W-1:0]  bit_cnt;
    logic              load_start;
    logic [15:0]       tail_inc;

    assign word_ready = (state_q == FETCH);
    assign busy       = (state_q != IDLE);
    assign load_start = (state_q == IDLE) && start && !abort;
    assign tail_inc   = (tail_ones == 16'hFFFF) ? tail_ones : tail_ones + {15'd0, ccff_tail};

    // Bit count check takes priority so a partial final word ends the load early.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (word_valid) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (bit_cnt == LAST_BIT) begin
                    state_d = FIN;
                end else if (sub_cnt == LAST_SUB) begin
                    state_d = FETCH;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_q     <= IDLE;
            shift_reg   <= '0;
            sub_cnt     <= '0;
            bit_cnt     <= '0;
            ccff_head   <= 1'b0;
            ccff_clk_en <= 1'b0;
            done        <= 1'b0;
            tail_ones   <= '0;
        end else begin
            state_q     <= state_d;
            done        <= 1'b0;
            ccff_clk_en <= 1'b0;
            // The chain shifts on every edge where the enable is high, so the tail bit leaves then.
            if (ccff_clk_en) begin
                tail_ones <= tail_inc;
            end
            case (state_q)
                IDLE: begin
                    if (load_start) begin
                        bit_cnt   <= '0;
                        tail_ones <= '0;
                    end
                end
                FETCH: begin
                    if (!abort && word_valid) begin
                        shift_reg <= word_in;
                        sub_cnt   <= '0;
                    end
                end
                SHIFT: begin
                    if (!abort) begin
                        ccff_head   <= shift_reg[sub_cnt];
                        ccff_clk_en <= 1'b1;
                        bit_cnt     <= bit_cnt + CNT_W'(1);
                        sub_cnt     <= sub_cnt + SUB_W'(1);
                    end
                end
                FIN: begin
                    if (!abort) begin
                        done <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef CCFF_CRC_EN
    logic [15:0] crc_step;

    assign crc_step = {crc[14:0], 1'b0} ^ ({16{crc[15] ^ ccff_head}} & 16'h1021);

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            crc <= '0;
        end else if (load_start) begin
            crc <= 16'hFFFF;
        end else if (ccff_clk_en) begin
            crc <= crc_step;
        end
    end
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Randomised bench for ccff_chain_loader: a chain model on ccff_tail plus a word-level reference.
// Build with +define+CCFF_CRC_EN to also check the CRC output.
module tb_ccff_chain_loader;

    localparam int CHAIN_LEN = 10;
    localparam int WORD_W    = 8;
    localparam int N_WORDS   = (CHAIN_LEN + WORD_W - 1) / WORD_W;

    logic              prog_clk = 1'b0;
    logic              prog_reset_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [WORD_W-1:0] word_in = '0;
    logic              word_valid = 1'b0;
    logic              word_ready;
    logic              ccff_head;
    logic              ccff_clk_en;
    logic              ccff_tail;
    logic              busy;
    logic              done;
    logic [15:0]       tail_ones;
`ifdef CCFF_CRC_EN
    logic [15:0]       crc;
`endif

    int error_count = 0;
    int check_count = 0;
    int cyc = 0;
    int pulse_cnt = 0;
    int last_pulse_cyc = 0;
    bit cap_bits[$];
    logic [CHAIN_LEN-1:0] chain = '1;

    ccff_chain_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W)) dut (
        .prog_clk    (prog_clk),
        .prog_reset_n(prog_reset_n),
        .start       (start),
        .abort       (abort),
        .word_in     (word_in),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .ccff_head   (ccff_head),
        .ccff_clk_en (ccff_clk_en),
        .ccff_tail   (ccff_tail),
        .busy        (busy),
        .done        (done),
        .tail_ones   (tail_ones)
`ifdef CCFF_CRC_EN
        ,
        .crc         (crc)
`endif
    );

    always #5 prog_clk = ~prog_clk;

    // Configuration chain: head enters bit 0, the tail is the oldest bit.
    assign ccff_tail = chain[CHAIN_LEN-1];

    always @(posedge prog_clk) begin
        cyc <= cyc + 1;
        if (ccff_clk_en) begin
            chain <= {chain[CHAIN_LEN-2:0], ccff_head};
        end
    end

    always @(negedge prog_clk) begin
        if (prog_reset_n && ccff_clk_en) begin
            cap_bits.push_back(ccff_head);
            pulse_cnt      = pulse_cnt + 1;
            last_pulse_cyc = cyc;
        end
    end

    task automatic tick;
        @(negedge prog_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic waitReady;
        int t;
        t = 0;
        while (!word_ready && t < 50) begin
            tick;
            t++;
        end
        checkOutput("fetch_timeout", 32'(t >= 50), 32'd0);
    endtask

    // One complete load; the reference is the LSB-first bit list of the words truncated to CHAIN_LEN.
    task automatic applyStimulus(input int stall_min, input int stall_max, input bit rand_start,
                                 input bit use_rand, input logic [WORD_W-1:0] w0,
                                 input logic [WORD_W-1:0] w1);
        logic [WORD_W-1:0]    w;
        bit                   exp_bits[$];
        int                   exp_ones;
        int                   t;
        int                   extra;
        int                   stall;
        logic [CHAIN_LEN-1:0] exp_vec;
        logic [CHAIN_LEN-1:0] got_vec;
        logic [CHAIN_LEN-1:0] exp_chain;
`ifdef CCFF_CRC_EN
        logic [15:0]          exp_crc;
        bit                   fb;
`endif
        exp_ones = 0;
        for (int i = 0; i < CHAIN_LEN; i++) begin
            exp_ones += int'(chain[i]);
        end
        cap_bits.delete();
        pulse_cnt = 0;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 0; k < N_WORDS; k++) begin
            w = use_rand ? WORD_W'($urandom) : ((k == 0) ? w0 : w1);
            for (int b = 0; b < WORD_W; b++) begin
                if (exp_bits.size() < CHAIN_LEN) begin
                    exp_bits.push_back(w[b]);
                end
            end
            word_valid = 1'b0;
            waitReady;
            stall = $urandom_range(stall_max, stall_min);
            for (int j = 0; j < stall; j++) begin
                if (j > 0) begin
                    checkOutput("stall_en", 32'(ccff_clk_en), 32'd0);
                end
                if (rand_start) begin
                    start = 1'($urandom_range(1, 0));
                end
                tick;
            end
            start      = 1'b0;
            word_in    = w;
            word_valid = 1'b1;
            tick;
        end
        word_in = WORD_W'($urandom);
        extra   = 0;
        t       = 0;
        while (!done && t < 200) begin
            if (word_ready) begin
                extra++;
            end
            tick;
            t++;
        end
        for (int i = 0; i < CHAIN_LEN; i++) begin
            exp_vec[i]               = exp_bits[i];
            got_vec[i]               = (i < cap_bits.size()) ? cap_bits[i] : 1'b0;
            exp_chain[CHAIN_LEN-1-i] = exp_bits[i];
        end
        checkOutput("done_seen", 32'(done), 32'd1);
        checkOutput("done_latency", 32'(cyc - last_pulse_cyc), 32'd1);
        checkOutput("busy_at_done", 32'(busy), 32'd0);
        checkOutput("pulse_count", 32'(pulse_cnt), 32'(CHAIN_LEN));
        checkOutput("extra_word", 32'(extra), 32'd0);
        checkOutput("head_bits", 32'(got_vec), 32'(exp_vec));
        checkOutput("chain_contents", 32'(chain), 32'(exp_chain));
        checkOutput("tail_ones", 32'(tail_ones), 32'(exp_ones));
`ifdef CCFF_CRC_EN
        exp_crc = 16'hFFFF;
        foreach (exp_bits[i]) begin
            fb      = exp_crc[15] ^ exp_bits[i];
            exp_crc = {exp_crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        checkOutput("crc", 32'(crc), 32'(exp_crc));
`endif
        word_valid = 1'b0;
        tick;
        checkOutput("done_one_cycle", 32'(done), 32'd0);
        checkOutput("tail_hold", 32'(tail_ones), 32'(exp_ones));
`ifdef CCFF_CRC_EN
        checkOutput("crc_hold", 32'(crc), 32'(exp_crc));
`endif
    endtask

    task automatic abortTest;
        int t;
        int done_hits;
        pulse_cnt = 0;
        start = 1'b1;
        tick;
        start = 1'b0;
        waitReady;
        word_in    = WORD_W'($urandom);
        word_valid = 1'b1;
        tick;
        word_valid = 1'b0;
        t = 0;
        while (pulse_cnt < 3 && t < 50) begin
            tick;
            t++;
        end
        checkOutput("abort_reach", 32'(pulse_cnt), 32'd3);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        checkOutput("abort_en", 32'(ccff_clk_en), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        done_hits = 0;
        for (int i = 0; i < 6; i++) begin
            done_hits += int'(done);
            tick;
        end
        checkOutput("abort_no_done", 32'(done_hits), 32'd0);
        checkOutput("abort_pulses", 32'(pulse_cnt), 32'd3);
        start = 1'b1;
        abort = 1'b1;
        tick;
        start = 1'b0;
        abort = 1'b0;
        checkOutput("start_abort_busy", 32'(busy), 32'd0);
        checkOutput("start_abort_ready", 32'(word_ready), 32'd0);
    endtask

    task automatic resetTest;
        int t;
        pulse_cnt = 0;
        start = 1'b1;
        tick;
        start = 1'b0;
        waitReady;
        word_in    = 8'hFF;
        word_valid = 1'b1;
        tick;
        word_valid = 1'b0;
        t = 0;
        while (pulse_cnt < 2 && t < 50) begin
            tick;
            t++;
        end
        checkOutput("reset_reach", 32'(pulse_cnt), 32'd2);
        prog_reset_n = 1'b0;
        #1;
        checkOutput("rst_mid_en", 32'(ccff_clk_en), 32'd0);
        checkOutput("rst_mid_head", 32'(ccff_head), 32'd0);
        checkOutput("rst_mid_busy", 32'(busy), 32'd0);
        checkOutput("rst_mid_ready", 32'(word_ready), 32'd0);
        checkOutput("rst_mid_tail", 32'(tail_ones), 32'd0);
        tick;
        prog_reset_n = 1'b1;
        tick;
        checkOutput("rst_after_pulses", 32'(pulse_cnt), 32'd2);
    endtask

    initial begin
        repeat (3) tick;
        prog_reset_n = 1'b1;
        tick;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_en", 32'(ccff_clk_en), 32'd0);
        checkOutput("rst_head", 32'(ccff_head), 32'd0);
        checkOutput("rst_ready", 32'(word_ready), 32'd0);
        checkOutput("rst_tail", 32'(tail_ones), 32'd0);
`ifdef CCFF_CRC_EN
        checkOutput("rst_crc", 32'(crc), 32'd0);
`endif
        applyStimulus(0, 0, 1'b0, 1'b0, 8'h3C, 8'hFF);
        applyStimulus(5, 5, 1'b0, 1'b0, 8'h00, 8'h00);
        applyStimulus(0, 0, 1'b0, 1'b0, 8'h00, 8'h00);
        abortTest;
        for (int n = 0; n < 8; n++) begin
            applyStimulus(0, 5, 1'b1, 1'b1, 8'h00, 8'h00);
        end
        resetTest;
        applyStimulus(0, 3, 1'b1, 1'b1, 8'h00, 8'h00);
        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
